// File: rtl/dac_sample_transmitter_pkg.sv
// Shared types and helpers for the DAC sample transmitter.
// State encoding, default frame geometry, sample code conversion.
package dac_sample_transmitter_pkg;

   localparam int DATA_BITS = 16;
   localparam int CMD_BITS  = 8;
   localparam int W         = CMD_BITS + DATA_BITS;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_LDAC
   } state_t;

   // Two's complement to offset binary is an MSB inversion;
   // the lower bits pass through unchanged.
   function automatic logic to_offset_binary_msb(
      input logic msb,
      input bit   offset_en
   );
      return offset_en ? ~msb : msb;
   endfunction

endpackage

// File: rtl/dac_sample_transmitter_shifter.sv
// spi_frame_shifter: serialises a W-bit frame MSB first, SPI mode 0.
// Ports: clk, reset (async low), frame/load, shift_en -> sclk, mosi, done.
module spi_frame_shifter #(
   parameter int W          = 24,
   parameter int clkDivider = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] frame,
   input  logic         load,
   input  logic         shift_en,
   output logic         sclk,
   output logic         mosi,
   output logic         done
);

   localparam int DIV_BITS = $clog2(clkDivider + 1);
   localparam int BIT_BITS = $clog2(W + 1);

   logic [W-1:0]        shreg;
   logic [DIV_BITS-1:0] div_cnt;
   logic [BIT_BITS-1:0] bit_cnt;
   logic                phase;
   logic                half_end;

   assign half_end = (div_cnt == DIV_BITS'(clkDivider - 1));
   assign done     = shift_en && phase && half_end
                     && (bit_cnt == '0);
   assign sclk     = phase;
   assign mosi     = shreg[W-1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shreg   <= '0;
         div_cnt <= '0;
         bit_cnt <= '0;
         phase   <= 1'b0;
      end else if (load) begin
         shreg   <= frame;
         div_cnt <= '0;
         bit_cnt <= BIT_BITS'(W - 1);
         phase   <= 1'b0;
      end else if (shift_en) begin
         if (half_end) begin
            div_cnt <= '0;
            phase   <= ~phase;
            // Advance on the falling edge, but keep bit 0 on the
            // line after the last high phase for the hold window.
            if (phase && (bit_cnt != '0)) begin
               shreg   <= {shreg[W-2:0], 1'b0};
               bit_cnt <= bit_cnt - 1'b1;
            end
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/dac_sample_transmitter.sv
// Sends controller samples to an SPI DAC as {command, data} frames.
// Ports: clk, reset (async low), sample/sample_valid, command, enable ->
//        sclk, cs_n, mosi, ldac_n, busy, sent_pulse, dropped_count.
module dac_sample_transmitter
   import dac_sample_transmitter_pkg::*;
#(
   parameter int dataBitSize     = DATA_BITS,
   parameter int cmdBitSize      = CMD_BITS,
   parameter int clkDivider      = 2,
   parameter int csSetupCycles   = 1,
   parameter int csHoldCycles    = 1,
   parameter int ldacCycles      = 1,
   parameter bit useOffsetBinary = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [dataBitSize-1:0] sample,
   input  logic                   sample_valid,
   input  logic [cmdBitSize-1:0]  command,
   input  logic                   enable,
   output logic                   sclk,
   output logic                   cs_n,
   output logic                   mosi,
   output logic                   ldac_n,
   output logic                   busy,
   output logic                   sent_pulse,
   output logic [15:0]            dropped_count
);

   localparam int FRAME_W = cmdBitSize + dataBitSize;

   state_t                 state, state_n;
   logic [15:0]            cnt, cnt_n;
   logic [dataBitSize-1:0] pend;
   logic                   pend_full;
   logic                   load_en;
   logic                   load;
   logic                   capture;
   logic                   sh_en;
   logic                   sh_done;
   logic                   sh_mosi;
   logic                   in_frame;
   logic [dataBitSize-1:0] data;
   logic [FRAME_W-1:0]     frame;

   assign capture = sample_valid && enable;

   always_comb begin
      data = pend;
      data[dataBitSize-1] =
         to_offset_binary_msb(pend[dataBitSize-1], useOffsetBinary);
   end

   assign frame = {command, data};

   // Holding buffer: latest sample wins; an unconsumed one is counted.
   // Load permission is registered so a re-enable behaves like a
   // fresh strobe (two cycles to chip select).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend          <= '0;
         pend_full     <= 1'b0;
         load_en       <= 1'b0;
         dropped_count <= '0;
      end else begin
         load_en <= enable;
         if (capture) begin
            pend      <= sample;
            pend_full <= 1'b1;
            if (pend_full && !load && (dropped_count != 16'hFFFF))
               dropped_count <= dropped_count + 16'd1;
         end else if (load) begin
            pend_full <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      load       = 1'b0;
      sh_en      = 1'b0;
      sent_pulse = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (pend_full && load_en) begin
               load    = 1'b1;
               state_n = ST_SETUP;
               cnt_n   = '0;
            end
         end
         ST_SETUP: begin
            if (cnt == 16'(csSetupCycles - 1)) begin
               state_n = ST_SHIFT;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         ST_SHIFT: begin
            sh_en = 1'b1;
            if (sh_done) begin
               state_n = ST_HOLD;
               cnt_n   = '0;
            end
         end
         ST_HOLD: begin
            if (cnt == 16'(csHoldCycles - 1)) begin
               state_n = ST_LDAC;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         ST_LDAC: begin
            if (cnt == 16'(ldacCycles - 1)) begin
               state_n    = ST_IDLE;
               cnt_n      = '0;
               sent_pulse = 1'b1;
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         default: begin
            state_n = ST_IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   spi_frame_shifter #(
      .W          (FRAME_W),
      .clkDivider (clkDivider)
   ) u_shifter (
      .clk      (clk),
      .reset    (reset),
      .frame    (frame),
      .load     (load),
      .shift_en (sh_en),
      .sclk     (sclk),
      .mosi     (sh_mosi),
      .done     (sh_done)
   );

   assign in_frame = (state == ST_SETUP) || (state == ST_SHIFT)
                     || (state == ST_HOLD);
   assign cs_n     = ~in_frame;
   assign mosi     = in_frame & sh_mosi;
   assign ldac_n   = (state != ST_LDAC);
   assign busy     = (state != ST_IDLE);

endmodule
